// File: rtl/password_lock_param.sv
// rtl/password_lock_param.sv - parametrised keypad lock with lockout, auto-relock and code reprogramming
module password_lock_param #(
    parameter int KEY_W         = 5,
    parameter int CODE_LEN      = 4,
    parameter int MAX_TRIES     = 3,
    parameter int LOCK_CYCLES   = 100,
    parameter int UNLOCK_CYCLES = 50,
    parameter int ENTER_KEY     = 21,
    parameter int CLEAR_KEY     = 20,
    parameter int PROG_KEY      = 22,
    parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = {5'd5, 5'd15, 5'd4, 5'd30}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] in,
    input  logic             key_valid,
    output logic             led,
    output logic             alarm,
    output logic [3:0]       seg,
    output logic [7:0]       seg_led,
    output logic [3:0]       tries_left
);
    localparam int BW   = CODE_LEN * KEY_W;
    localparam int CW   = $clog2(CODE_LEN + 2);
    localparam int TMAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_PROG, S_LOCKOUT
    } state_t;

    state_t        state;
    logic [BW-1:0] code;
    logic [BW-1:0] buffer;
    logic [CW-1:0] count;
    logic [3:0]    fails;
    logic [TW-1:0] timer;

    logic          is_enter, is_clear, is_prog, is_digit;
    logic          overflow_next;
    logic [CW-1:0] count_inc;
    logic [BW-1:0] buffer_shift;
    logic [3:0]    count_seg;
    logic [3:0]    fails_inc;
    logic          match;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign is_enter = key_valid && (in == KEY_W'(ENTER_KEY));
    assign is_clear = key_valid && (in == KEY_W'(CLEAR_KEY));
    assign is_prog  = key_valid && (in == KEY_W'(PROG_KEY));
    assign is_digit = key_valid && !is_enter && !is_clear && !is_prog;

    // count saturates one past CODE_LEN; that value flags an overlong entry
    assign count_inc     = (count == CW'(CODE_LEN + 1)) ? count : count + 1'b1;
    assign overflow_next = (count_inc == CW'(CODE_LEN + 1));
    assign buffer_shift  = (count < CW'(CODE_LEN)) ? ((buffer << KEY_W) | BW'(in)) : buffer;
    assign count_seg     = overflow_next ? 4'hF : 4'(count_inc);
    assign fails_inc     = fails + 4'd1;
    assign match         = (count == CW'(CODE_LEN)) && (buffer == code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            code       <= DEFAULT_CODE;
            buffer     <= '0;
            count      <= '0;
            fails      <= '0;
            timer      <= '0;
            led        <= 1'b0;
            alarm      <= 1'b0;
            seg        <= 4'h0;
            seg_led    <= 8'h3F;
            tries_left <= 4'(MAX_TRIES);
        end else begin
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (is_digit) begin
                        buffer  <= buffer_shift;
                        count   <= count_inc;
                        state   <= S_ENTRY;
                        seg     <= count_seg;
                        seg_led <= {1'b0, hex7(count_seg)};
                    end else if (is_enter) begin
                        state <= S_CHECK;
                    end else if (is_clear) begin
                        buffer  <= '0;
                        count   <= '0;
                        state   <= S_IDLE;
                        seg     <= 4'h0;
                        seg_led <= {1'b0, hex7(4'h0)};
                    end
                end
                S_CHECK: begin
                    buffer <= '0;
                    count  <= '0;
                    if (match) begin
                        state      <= S_UNLOCKED;
                        led        <= 1'b1;
                        fails      <= '0;
                        tries_left <= 4'(MAX_TRIES);
                        timer      <= TW'(UNLOCK_CYCLES - 1);
                        seg        <= 4'hA;
                        seg_led    <= {1'b0, hex7(4'hA)};
                    end else if (fails_inc == 4'(MAX_TRIES)) begin
                        state      <= S_LOCKOUT;
                        fails      <= fails_inc;
                        tries_left <= 4'(MAX_TRIES) - fails_inc;
                        alarm      <= 1'b1;
                        timer      <= TW'(LOCK_CYCLES - 1);
                        seg        <= 4'hE;
                        seg_led    <= {1'b1, hex7(4'hE)};
                    end else begin
                        state      <= S_IDLE;
                        fails      <= fails_inc;
                        tries_left <= 4'(MAX_TRIES) - fails_inc;
                        seg        <= 4'h0;
                        seg_led    <= {1'b0, hex7(4'h0)};
                    end
                end
                S_UNLOCKED: begin
                    // relock wins over a PROG key arriving on the final cycle
                    if (timer == '0) begin
                        state   <= S_IDLE;
                        led     <= 1'b0;
                        seg     <= 4'h0;
                        seg_led <= {1'b0, hex7(4'h0)};
                    end else if (is_prog) begin
                        state   <= S_PROG;
                        seg     <= 4'hB;
                        seg_led <= {1'b0, hex7(4'hB)};
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_PROG: begin
                    if (is_digit) begin
                        buffer <= buffer_shift;
                        count  <= count_inc;
                    end else if (is_enter || is_clear) begin
                        buffer <= '0;
                        count  <= '0;
                        if (is_enter && count == CW'(CODE_LEN)) begin
                            code    <= buffer;
                            state   <= S_IDLE;
                            led     <= 1'b0;
                            seg     <= 4'h0;
                            seg_led <= {1'b0, hex7(4'h0)};
                        end else begin
                            state   <= S_UNLOCKED;
                            seg     <= 4'hA;
                            seg_led <= {1'b0, hex7(4'hA)};
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= S_IDLE;
                        alarm      <= 1'b0;
                        fails      <= '0;
                        tries_left <= 4'(MAX_TRIES);
                        seg        <= 4'h0;
                        seg_led    <= {1'b0, hex7(4'h0)};
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_password_lock_param.sv
// tb/tb_password_lock_param.sv - randomized scoreboard bench for password_lock_param
module tb_password_lock_param;
    localparam int KEY_W = 5, CODE_LEN = 4, MAX_TRIES = 3;
    localparam int LOCK_CYCLES = 100, UNLOCK_CYCLES = 50;
    localparam int ENTER = 21, CLEAR = 20, PROG = 22;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_PROG = 4, M_LOCK = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic [KEY_W-1:0] in_key = '0;
    logic             led, alarm;
    logic [3:0]       seg, tries_left;
    logic [7:0]       seg_led;

    typedef struct packed {
        logic       led;
        logic       alarm;
        logic [3:0] seg;
        logic [7:0] seg_led;
        logic [3:0] tries;
    } out_t;

    out_t exp_q[$];
    int   tests = 0;
    int   failures = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int def_code [CODE_LEN] = '{5, 15, 4, 30};

    int m_mode, m_typed, m_fails, m_tmr, m_seg;
    int m_entry[$];
    int m_code [CODE_LEN];
    bit m_led, m_alarm;

    always #5 clk = ~clk;

    password_lock_param #(
        .KEY_W(KEY_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES),
        .ENTER_KEY(ENTER), .CLEAR_KEY(CLEAR), .PROG_KEY(PROG)
    ) dut (
        .clk(clk), .rst(rst), .in(in_key), .key_valid(key_valid),
        .led(led), .alarm(alarm), .seg(seg), .seg_led(seg_led), .tries_left(tries_left)
    );

    function automatic out_t expected();
        out_t e;
        e.led     = m_led;
        e.alarm   = m_alarm;
        e.seg     = 4'(m_seg);
        e.seg_led = {m_alarm, hex_tab[m_seg]};
        e.tries   = 4'(MAX_TRIES - m_fails);
        return e;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_entry.delete(); m_typed = 0;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = def_code[i];
        m_fails = 0; m_tmr = 0; m_led = 0; m_alarm = 0; m_seg = 0;
    endfunction

    function automatic void clear_entry();
        m_entry.delete();
        m_typed = 0;
    endfunction

    // the entry keeps the first CODE_LEN digits; typing more only marks it too long
    function automatic void add_digit(input int k);
        if (m_entry.size() < CODE_LEN) m_entry.push_back(k);
        if (m_typed <= CODE_LEN) m_typed++;
    endfunction

    function automatic void model_step(input bit kv, input int k);
        bit ctl;
        bit ok;
        ctl = (k == ENTER) || (k == CLEAR) || (k == PROG);
        case (m_mode)
            M_IDLE, M_ENTRY: if (kv) begin
                if (!ctl) begin
                    add_digit(k);
                    m_mode = M_ENTRY;
                    m_seg  = (m_typed > CODE_LEN) ? 15 : m_typed;
                end else if (k == ENTER) begin
                    m_mode = M_CHECK;
                end else if (k == CLEAR) begin
                    clear_entry();
                    m_mode = M_IDLE;
                    m_seg  = 0;
                end
            end
            M_CHECK: begin
                ok = (m_typed == CODE_LEN);
                if (ok) for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 0;
                clear_entry();
                if (ok) begin
                    m_mode = M_OPEN; m_led = 1; m_fails = 0; m_tmr = UNLOCK_CYCLES - 1; m_seg = 10;
                end else begin
                    m_fails++;
                    if (m_fails == MAX_TRIES) begin
                        m_mode = M_LOCK; m_alarm = 1; m_tmr = LOCK_CYCLES - 1; m_seg = 14;
                    end else begin
                        m_mode = M_IDLE; m_seg = 0;
                    end
                end
            end
            M_OPEN: begin
                if (m_tmr == 0) begin
                    m_mode = M_IDLE; m_led = 0; m_seg = 0;
                end else if (kv && k == PROG) begin
                    m_mode = M_PROG; m_seg = 11;
                end else begin
                    m_tmr--;
                end
            end
            M_PROG: if (kv) begin
                if (!ctl) begin
                    add_digit(k);
                end else if (k == ENTER) begin
                    if (m_typed == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_entry[i];
                        m_mode = M_IDLE; m_led = 0; m_seg = 0;
                    end else begin
                        m_mode = M_OPEN; m_seg = 10;
                    end
                    clear_entry();
                end else if (k == CLEAR) begin
                    clear_entry();
                    m_mode = M_OPEN; m_seg = 10;
                end
            end
            M_LOCK: begin
                if (m_tmr == 0) begin
                    m_mode = M_IDLE; m_alarm = 0; m_fails = 0; m_seg = 0;
                end else begin
                    m_tmr--;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    function automatic int rand_digit();
        int v;
        do v = $urandom_range(0, 31); while (v >= 20 && v <= 22);
        return v;
    endfunction

    task automatic tick(input bit kv, input int k);
        @(negedge clk);
        rst       = 1'b0;
        key_valid = kv;
        in_key    = kv ? KEY_W'(k) : KEY_W'($urandom_range(0, 31));
        model_step(kv, k);
        exp_q.push_back(expected());
    endtask

    task automatic press(input int k);
        tick(1'b1, k);
    endtask

    task automatic gap(input int n);
        repeat (n) tick(1'b0, 0);
    endtask

    task automatic keys4(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic enter_model_code();
        for (int i = 0; i < CODE_LEN; i++) press(m_code[i]);
        press(ENTER);
    endtask

    task automatic do_reset();
        out_t got;
        out_t rv;
        @(negedge clk);
        rst       = 1'b1;
        key_valid = 1'b0;
        #1;
        rv  = '{led: 1'b0, alarm: 1'b0, seg: 4'h0, seg_led: 8'h3F, tries: 4'(MAX_TRIES)};
        got = '{led: led, alarm: alarm, seg: seg, seg_led: seg_led, tries: tries_left};
        tests++;
        if (got !== rv) begin
            failures++;
            $display("FAIL async_reset: got %h required %h", got, rv);
        end
        model_reset();
        exp_q.push_back(expected());
    endtask

    initial begin : monitor
        out_t e;
        out_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{led: led, alarm: alarm, seg: seg, seg_led: seg_led, tries: tries_left};
                tests++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got led=%b alarm=%b seg=%h seg_led=%h tries=%0d, required led=%b alarm=%b seg=%h seg_led=%h tries=%0d",
                             $time, got.led, got.alarm, got.seg, got.seg_led, got.tries,
                             e.led, e.alarm, e.seg, e.seg_led, e.tries);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        model_reset();
        do_reset();

        keys4(5, 15, 4, 30); press(ENTER); gap(55);

        press(ENTER); keys4(8, 7, 2, 1); press(ENTER); gap(2);
        keys4(5, 15, 4, 30); press(ENTER); gap(55);

        repeat (3) begin keys4(1, 2, 3, 4); press(ENTER); gap(2); end
        keys4(5, 15, 4, 30); press(ENTER); gap(105);

        press(5); press(15); press(CLEAR); gap(1);
        keys4(5, 15, 4, 30); press(9); press(ENTER); gap(3);

        keys4(5, 15, 4, 30); press(ENTER); gap(3);
        press(PROG); keys4(1, 2, 3, 4); press(ENTER); gap(3);
        keys4(5, 15, 4, 30); press(ENTER); gap(3);
        keys4(1, 2, 3, 4); press(ENTER); gap(3);
        press(PROG); press(7); press(8); press(9); press(ENTER); gap(60);
        keys4(1, 2, 3, 4); press(ENTER); gap(3);
        press(PROG); press(9); press(9); do_reset();
        keys4(5, 15, 4, 30); press(ENTER); gap(55);

        repeat (3) begin keys4(9, 9, 9, 9); press(ENTER); end
        gap(20); do_reset();
        keys4(5, 15, 4, 30); press(ENTER); gap(55);

        repeat (70) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    enter_model_code();
                    gap($urandom_range(0, 5));
                    if ($urandom_range(0, 1) == 1) begin
                        press(PROG);
                        n = $urandom_range(2, 5);
                        repeat (n) press(rand_digit());
                        if ($urandom_range(0, 3) == 0) press(CLEAR); else press(ENTER);
                    end
                    gap($urandom_range(0, 60));
                end
                3, 4, 5: begin
                    n = $urandom_range(0, 6);
                    repeat (n) press(rand_digit());
                    if ($urandom_range(0, 3) == 0) press(CLEAR); else press(ENTER);
                    gap($urandom_range(0, 3));
                end
                6: repeat (12) tick(1'($urandom_range(0, 1)), $urandom_range(0, 31));
                7: gap($urandom_range(0, 110));
                8: do_reset();
                default: repeat (3) begin
                    repeat (4) press(rand_digit());
                    press(ENTER);
                end
            endcase
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failures++;
            $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
